// File: rtl/pcm_interp.sv
// pcm_interp: linear interpolator from a slow PCM sample stream to a
// per-clk_fast output word for a 1-bit modulator.
//
// Each accepted sample becomes the end point of a straight-line segment
// lasting N = 2^RATIO_LOG2 clk_fast cycles. The accumulator is re-anchored
// exactly on the segment start value at every segment boundary, so rounding
// error in the per-cycle step never accumulates across segments.
//
// Ports
//   clk_fast  in   single clock, rising edge
//   rst       in   asynchronous, active-high reset
//   s_data    in   IW-bit signed PCM sample
//   s_valid   in   s_data valid
//   s_ready   out  sample accepted on a rising edge when s_valid & s_ready
//   dout      out  W-bit offset-binary interpolated value (midscale 2^(W-1))
//   underrun  out  high for the single boundary cycle that found no sample
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no sample seen since reset; output parked at midscale
// RUN   | interpolating; phase counts the position within the segment

module pcm_interp #(
    parameter int W          = 12,
    parameter int IW         = 16,
    parameter int RATIO_LOG2 = 8
) (
    input  logic          clk_fast,
    input  logic          rst,
    input  logic [IW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [W-1:0]  dout,
    output logic          underrun
);

    localparam int AW = IW + RATIO_LOG2 + 1;
    localparam logic [RATIO_LOG2-1:0] PH_LAST = '1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic [IW-1:0]         nxt;
    logic                  nxt_full;
    logic [IW-1:0]         target;
    logic [IW:0]           step;
    logic [AW-1:0]         acc;
    logic [RATIO_LOG2-1:0] phase;

    logic          wrap;
    logic          accept;
    logic [IW:0]   step_new;
    logic [AW-1:0] anchor;
    logic [AW-1:0] step_ext;

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wrap      = 1'b0;
        s_ready   = 1'b0;
        accept    = 1'b0;
        underrun  = 1'b0;
        case (state)
            IDLE: begin
                s_ready = ~rst;
                accept  = s_valid & s_ready;
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                wrap     = (phase == PH_LAST);
                s_ready  = ~rst & (~nxt_full | wrap);
                accept   = s_valid & s_ready;
                underrun = wrap & ~nxt_full;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Difference is taken at IW+1 bits so a full-scale swing cannot wrap.
    assign step_new = {nxt[IW-1], nxt} - {target[IW-1], target};
    assign anchor   = {{(AW-IW){target[IW-1]}}, target} << RATIO_LOG2;
    assign step_ext = {{(AW-IW-1){step[IW]}}, step};

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            nxt      <= '0;
            nxt_full <= 1'b0;
            target   <= '0;
            step     <= '0;
            acc      <= '0;
            phase    <= '0;
        end else begin
            // A fill on a boundary cycle overlaps the consume of the old entry.
            if (accept) begin
                nxt      <= s_data;
                nxt_full <= 1'b1;
            end else if (wrap) begin
                nxt_full <= 1'b0;
            end

            if (state == IDLE) begin
                // Start one cycle before a boundary so the first sample is
                // consumed immediately and ramps up from zero.
                if (accept) begin
                    phase <= PH_LAST;
                end
            end else begin
                phase <= phase + 1'b1;
                if (wrap) begin
                    acc <= anchor;
                    if (nxt_full) begin
                        step   <= step_new;
                        target <= nxt;
                    end else begin
                        step <= '0;
                    end
                end else begin
                    acc <= acc + step_ext;
                end
            end
        end
    end

    // Taking acc[IW-1+RATIO_LOG2:RATIO_LOG2] is the floor arithmetic shift;
    // inverting the sign bit converts two's complement to offset binary.
    assign dout = {~acc[IW-1+RATIO_LOG2], acc[IW-2+RATIO_LOG2 -: W-1]};

endmodule

// File: tb/tb_pcm_interp.sv
module tb_pcm_interp;

    localparam int W  = 12;
    localparam int IW = 16;
    localparam int R  = 8;

    logic          clk_fast = 1'b0;
    logic          rst      = 1'b1;
    logic [IW-1:0] s_data   = '0;
    logic          s_valid  = 1'b0;
    logic          s_ready;
    logic [W-1:0]  dout;
    logic          underrun;

    int n_tests = 0;
    int n_fail  = 0;

    pcm_interp #(.W(W), .IW(IW), .RATIO_LOG2(R)) dut (
        .clk_fast (clk_fast),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .dout     (dout),
        .underrun (underrun)
    );

    always #5 clk_fast = ~clk_fast;

    typedef struct {
        logic [15:0] s;
        logic [11:0] half;   // dout after edge 129 from acceptance
        logic [11:0] full;   // dout after edge 257 from acceptance
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        ticks(2);
        rst = 1'b0;
        tick();
    endtask

    // Returns just after the accepting edge.
    task automatic send(input logic [IW-1:0] v);
        s_data  = v;
        s_valid = 1'b1;
        for (int i = 0; i < 600 && !s_ready; i++) tick();
        check("accept_ready", s_ready, 1);
        tick();
        s_valid = 1'b0;
    endtask

    function automatic logic [11:0] offs(input logic [15:0] v);
        return {~v[15], v[14:4]};
    endfunction

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_acc;
        int und_seen;
        int nonmono;
        int acc_cyc[$];
        logic [15:0] sent[$];
        logic [11:0] prev;
        bit will;

        // Offset-binary value at half-way is floor(s/2), at the end s itself.
        vt[0] = '{16'h4000, 12'hA00, 12'hC00};
        vt[1] = '{16'h7FFF, 12'hBFF, 12'hFFF};
        vt[2] = '{16'h8000, 12'h400, 12'h000};
        vt[3] = '{16'hFFFF, 12'h7FF, 12'h7FF};
        vt[4] = '{16'h0010, 12'h800, 12'h801};
        vt[5] = '{16'hC000, 12'h600, 12'h400};
        vt[6] = '{16'h1234, 12'h891, 12'h923};

        #1;
        check("rst_dout", dout, 12'h800);
        check("rst_ready", s_ready, 0);
        check("rst_underrun", underrun, 0);
        ticks(2);
        rst = 1'b0;
        tick();
        check("idle_ready", s_ready, 1);
        check("idle_dout", dout, 12'h800);

        // Single sample from IDLE: edge 0 accepts, edge 1 consumes,
        // edges 2..256 step, edge 257 re-anchors on the sample.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            send(vt[i].s);
            check("vec_e0", dout, 12'h800);
            tick();
            check("vec_e1", dout, 12'h800);
            ticks(128);
            check("vec_half", dout, vt[i].half);
            ticks(127);
            check("vec_underrun_e256", underrun, 1);
            tick();
            check("vec_full", dout, vt[i].full);
            check("vec_underrun_e257", underrun, 0);
        end

        // Sustained underrun repeats at every boundary and holds the value.
        do_reset();
        send(16'h7FFF);
        ticks(256);
        check("und1_pulse", underrun, 1);
        tick();
        check("und1_low", underrun, 0);
        check("und1_dout", dout, 12'hFFF);
        ticks(255);
        check("und2_pulse", underrun, 1);
        check("und2_dout", dout, 12'hFFF);
        tick();
        check("und2_low", underrun, 0);
        check("und2_hold", dout, 12'hFFF);

        // Full-scale fall 0x7FFF -> 0x8000.
        do_reset();
        send(16'h7FFF);
        send(16'h8000);
        ticks(255);
        tick();
        check("fall_start", dout, 12'hFFF);
        prev     = dout;
        nonmono  = 0;
        und_seen = 0;
        for (int j = 1; j <= 255; j++) begin
            if (underrun) und_seen++;
            tick();
            if (dout > prev) nonmono++;
            prev = dout;
            if (j == 128) check("fall_mid", dout, 12'h7FF);
        end
        check("fall_monotonic", nonmono, 0);
        check("fall_no_underrun", und_seen, 0);
        tick();
        check("fall_end", dout, 12'h000);

        // Continuous stream: consume+fill on every boundary.
        do_reset();
        s_valid  = 1'b1;
        s_data   = 16'h1357;
        n_acc    = 0;
        und_seen = 0;
        for (int c = 1; c <= 1400; c++) begin
            will = s_ready;
            if (underrun) und_seen++;
            tick();
            if (will) begin
                sent.push_back(s_data);
                acc_cyc.push_back(c);
                n_acc++;
                if (sent.size() >= 3)
                    check("stream_anchor", dout, offs(sent[sent.size()-3]));
                s_data = s_data + 16'h2F1B;
            end
        end
        s_valid = 1'b0;
        check("stream_count", n_acc, 7);
        check("stream_no_underrun", und_seen, 0);
        if (acc_cyc.size() >= 2)
            check("stream_first_gap", acc_cyc[1] - acc_cyc[0], 1);
        for (int j = 2; j < acc_cyc.size(); j++)
            check("stream_gap", acc_cyc[j] - acc_cyc[j-1], 256);

        // Async reset mid-ramp with a pending sample, then a fresh ramp.
        do_reset();
        send(16'h7FFF);
        send(16'h8000);
        ticks(50);
        #3;
        rst = 1'b1;
        #1;
        check("arst_dout", dout, 12'h800);
        check("arst_ready", s_ready, 0);
        check("arst_underrun", underrun, 0);
        ticks(2);
        rst = 1'b0;
        tick();
        send(16'h4000);
        check("post_e0", dout, 12'h800);
        tick();
        check("post_e1", dout, 12'h800);
        tick();
        check("post_e2", dout, 12'h804);
        ticks(126);
        check("post_e128", dout, 12'h9FC);
        tick();
        check("post_e129", dout, 12'hA00);
        check("post_no_underrun", underrun, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
